// File: rtl/cacheline_arbiter_pkg.sv
// Shared cache package: arbiter FSM state and grant encodings, plus the
// default byte-offset width of a 256-bit cacheline (32 bytes -> 5 bits).
package cacheline_arbiter_pkg;

  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  // Which requester received the most recent grant. This is the round-robin memory.
  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//   Serialises icache line reads and dcache eviction-buffer line reads/writes
//   onto a single downstream cacheline port. Only one transaction is in flight
//   at a time. When both sides request, the side that was not granted last wins.
// Ports
//   clk, rst                        clock; synchronous active-high reset
//   from_icache_address/read        icache request (held until to_icache_resp)
//   to_icache_rdata/resp            icache completion (resp is a one-cycle pulse)
//   from_dcache_address/read/write  eviction-buffer request
//   from_dcache_wdata               writeback data, held with from_dcache_write
//   to_dcache_rdata/resp            eviction-buffer completion
//   to_mem_address/read/write/wdata downstream request (line-aligned address)
//   from_mem_rdata/resp             downstream completion
module cacheline_arbiter #(
  parameter int cacheline_size = 256,
  parameter int OFFSET_BITS    = cacheline_arbiter_pkg::OFFSET_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               from_icache_address,
  input  logic                      from_icache_read,
  output logic [cacheline_size-1:0] to_icache_rdata,
  output logic                      to_icache_resp,
  input  logic [31:0]               from_dcache_address,
  input  logic                      from_dcache_read,
  input  logic                      from_dcache_write,
  input  logic [cacheline_size-1:0] from_dcache_wdata,
  output logic [cacheline_size-1:0] to_dcache_rdata,
  output logic                      to_dcache_resp,
  output logic [31:0]               to_mem_address,
  output logic                      to_mem_read,
  output logic                      to_mem_write,
  output logic [cacheline_size-1:0] to_mem_wdata,
  input  logic [cacheline_size-1:0] from_mem_rdata,
  input  logic                      from_mem_resp
);

  import cacheline_arbiter_pkg::arb_state_t;
  import cacheline_arbiter_pkg::ARB_IDLE;
  import cacheline_arbiter_pkg::ARB_SERVE_I;
  import cacheline_arbiter_pkg::ARB_SERVE_D;
  import cacheline_arbiter_pkg::arb_grant_t;
  import cacheline_arbiter_pkg::GRANT_I;
  import cacheline_arbiter_pkg::GRANT_D;

  localparam logic [31:0] offset_mask = (32'd1 << OFFSET_BITS) - 32'd1;

  arb_state_t  state, state_next;
  arb_grant_t  last_grant;
  logic [31:0] grant_address;
  logic        req_i, req_d;

  assign req_i = from_icache_read;
  assign req_d = from_dcache_read | from_dcache_write;

  // Next-state logic. A downstream resp seen in IDLE has no effect because only
  // the SERVE states look at it.
  always_comb begin
    // NOTE: assign a default before the case so that every path drives the
    // signal. Otherwise synthesis infers a latch.
    state_next = state;
    unique case (state)
      ARB_IDLE: begin
        if (req_i && req_d)
          state_next = (last_grant == GRANT_I) ? ARB_SERVE_D : ARB_SERVE_I;
        else if (req_i)
          state_next = ARB_SERVE_I;
        else if (req_d)
          state_next = ARB_SERVE_D;
      end
      ARB_SERVE_I,
      ARB_SERVE_D: begin
        if (from_mem_resp)
          state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Output and routing logic. All outputs are 0 in IDLE. Read data and resp are
  // passed through combinationally to the granted side only.
  always_comb begin
    to_mem_address  = '0;
    to_mem_read     = 1'b0;
    to_mem_write    = 1'b0;
    to_mem_wdata    = '0;
    to_icache_rdata = '0;
    to_icache_resp  = 1'b0;
    to_dcache_rdata = '0;
    to_dcache_resp  = 1'b0;
    unique case (state)
      ARB_SERVE_I: begin
        to_mem_read     = 1'b1;
        to_mem_address  = grant_address & ~offset_mask;
        to_icache_rdata = from_mem_rdata;
        to_icache_resp  = from_mem_resp;
      end
      ARB_SERVE_D: begin
        // A write wins over a simultaneous (illegal) read.
        to_mem_write    = from_dcache_write;
        to_mem_read     = ~from_dcache_write;
        to_mem_wdata    = from_dcache_wdata;
        to_mem_address  = grant_address & ~offset_mask;
        to_dcache_rdata = from_mem_rdata;
        to_dcache_resp  = from_mem_resp;
      end
      default: ;
    endcase
  end

  // The address is captured when a grant is made, so the requester's value at
  // grant time is the one presented downstream for the whole transaction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples its pre-edge value, independent of statement order.
    if (rst) begin
      state         <= ARB_IDLE;
      last_grant    <= GRANT_D;
      grant_address <= '0;
    end else begin
      state <= state_next;
      if (state == ARB_IDLE && state_next != ARB_IDLE) begin
        if (state_next == ARB_SERVE_I) begin
          grant_address <= from_icache_address;
          last_grant    <= GRANT_I;
        end else begin
          grant_address <= from_dcache_address;
          last_grant    <= GRANT_D;
        end
      end
    end
  end

  // The eviction buffer must never ask for a read and a write at once.
  dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(from_dcache_read && from_dcache_write))
    else $error("cacheline_arbiter: simultaneous dcache read and write");

endmodule
